// File: rtl/create_huffman_tree.sv
// Builds a 4-leaf Huffman tree from leaf weights and emits 7 packed node words {parent, branch, weight}.
// Define ZERO_WEIGHT_BUMP_EN to load zero leaf weights as 1.
module create_huffman_tree #(
    parameter int          WEIGHT_W    = 8,
    parameter logic [3:0]  ROOT_TAG    = 4'hF,
    parameter logic [1:0]  BUILD_STATE = 2'b01
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [1:0]            state,
    input  logic [WEIGHT_W-1:0]   weight_1,
    input  logic [WEIGHT_W-1:0]   weight_2,
    input  logic [WEIGHT_W-1:0]   weight_3,
    input  logic [WEIGHT_W-1:0]   weight_4,
    output logic [WEIGHT_W+4:0]   info_node_1,
    output logic [WEIGHT_W+4:0]   info_node_2,
    output logic [WEIGHT_W+4:0]   info_node_3,
    output logic [WEIGHT_W+4:0]   info_node_4,
    output logic [WEIGHT_W+4:0]   info_node_5,
    output logic [WEIGHT_W+4:0]   info_node_6,
    output logic [WEIGHT_W+4:0]   info_node_7,
    output logic                  done,
    output logic                  sat
);
    localparam int NW = WEIGHT_W + 5;

    // The leaf load happens on the IDLE exit edge, so scanning starts on the next cycle.
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_MERGE, S_DONE} fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [NW-1:0]       node_q [7];
    logic [NW-1:0]       node_d [7];
    logic [6:0]          valid_q, valid_d;
    logic [2:0]          scan_idx_q, scan_idx_d;
    logic [1:0]          merge_cnt_q, merge_cnt_d;
    logic [2:0]          min1_q, min1_d, min2_q, min2_d;
    logic                min1_vld_q, min1_vld_d, min2_vld_q, min2_vld_d;
    logic                sat_q, sat_d, done_q, done_d;

    logic [WEIGHT_W-1:0] w_in   [4];
    logic [WEIGHT_W-1:0] w_load [4];
    logic                build;
    logic [NW-1:0]       cur;
    logic                cur_active;
    logic [WEIGHT_W-1:0] cur_w, w1, w2, new_w;
    logic [WEIGHT_W:0]   sum;
    logic [2:0]          new_idx;
    logic [3:0]          new_num;

    assign w_in[0] = weight_1;
    assign w_in[1] = weight_2;
    assign w_in[2] = weight_3;
    assign w_in[3] = weight_4;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_load
`ifdef ZERO_WEIGHT_BUMP_EN
            assign w_load[gi] = (w_in[gi] == '0) ? WEIGHT_W'(1) : w_in[gi];
`else
            assign w_load[gi] = w_in[gi];
`endif
        end
    endgenerate

    assign build      = (state == BUILD_STATE);
    assign cur        = node_q[scan_idx_q];
    assign cur_w      = cur[WEIGHT_W-1:0];
    assign cur_active = valid_q[scan_idx_q] && (cur[NW-1 -: 4] == ROOT_TAG);
    assign w1         = node_q[min1_q][WEIGHT_W-1:0];
    assign w2         = node_q[min2_q][WEIGHT_W-1:0];
    assign sum        = {1'b0, w1} + {1'b0, w2};
    assign new_w      = sum[WEIGHT_W] ? '1 : sum[WEIGHT_W-1:0];
    assign new_idx    = 3'd4 + {1'b0, merge_cnt_q};
    assign new_num    = 4'd5 + {2'b00, merge_cnt_q};

    always_comb begin
        fsm_d       = fsm_q;
        node_d      = node_q;
        valid_d     = valid_q;
        scan_idx_d  = scan_idx_q;
        merge_cnt_d = merge_cnt_q;
        min1_d      = min1_q;
        min2_d      = min2_q;
        min1_vld_d  = min1_vld_q;
        min2_vld_d  = min2_vld_q;
        sat_d       = sat_q;
        done_d      = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (build) begin
                    for (int i = 0; i < 4; i++) node_d[i] = {ROOT_TAG, 1'b0, w_load[i]};
                    for (int i = 4; i < 7; i++) node_d[i] = '0;
                    valid_d     = 7'b000_1111;
                    scan_idx_d  = '0;
                    merge_cnt_d = '0;
                    min1_vld_d  = 1'b0;
                    min2_vld_d  = 1'b0;
                    sat_d       = 1'b0;
                    fsm_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!build) begin
                    fsm_d = S_IDLE;
                end else begin
                    // Strict < while scanning upward makes the lower index win ties.
                    if (cur_active) begin
                        if (!min1_vld_q || cur_w < w1) begin
                            min2_d     = min1_q;
                            min2_vld_d = min1_vld_q;
                            min1_d     = scan_idx_q;
                            min1_vld_d = 1'b1;
                        end else if (!min2_vld_q || cur_w < w2) begin
                            min2_d     = scan_idx_q;
                            min2_vld_d = 1'b1;
                        end
                    end
                    if (scan_idx_q == 3'd6) begin
                        scan_idx_d = '0;
                        fsm_d      = S_MERGE;
                    end else begin
                        scan_idx_d = scan_idx_q + 3'd1;
                    end
                end
            end
            S_MERGE: begin
                if (!build) begin
                    fsm_d = S_IDLE;
                end else begin
                    node_d[new_idx]  = {ROOT_TAG, 1'b0, new_w};
                    valid_d[new_idx] = 1'b1;
                    node_d[min1_q]   = {new_num, 1'b0, w1};
                    node_d[min2_q]   = {new_num, 1'b1, w2};
                    if (sum[WEIGHT_W]) sat_d = 1'b1;
                    merge_cnt_d = merge_cnt_q + 2'd1;
                    min1_vld_d  = 1'b0;
                    min2_vld_d  = 1'b0;
                    fsm_d       = (merge_cnt_q == 2'd2) ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                if (build) done_d = 1'b1;
                else       fsm_d  = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            fsm_q       <= S_IDLE;
            for (int i = 0; i < 7; i++) node_q[i] <= '0;
            valid_q     <= '0;
            scan_idx_q  <= '0;
            merge_cnt_q <= '0;
            min1_q      <= '0;
            min2_q      <= '0;
            min1_vld_q  <= 1'b0;
            min2_vld_q  <= 1'b0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            node_q      <= node_d;
            valid_q     <= valid_d;
            scan_idx_q  <= scan_idx_d;
            merge_cnt_q <= merge_cnt_d;
            min1_q      <= min1_d;
            min2_q      <= min2_d;
            min1_vld_q  <= min1_vld_d;
            min2_vld_q  <= min2_vld_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
        end
    end

    assign info_node_1 = node_q[0];
    assign info_node_2 = node_q[1];
    assign info_node_3 = node_q[2];
    assign info_node_4 = node_q[3];
    assign info_node_5 = node_q[4];
    assign info_node_6 = node_q[5];
    assign info_node_7 = node_q[6];
    assign done        = done_q;
    assign sat         = sat_q;
endmodule
